// File: rtl/fxp_accumulate_stage.sv
// fxp_accumulate_stage
//   Accumulates a burst of signed fixed-point products into a saturating running sum.
//   A burst starts in IDLE on `start` and runs for `len` beats. Each beat either adds
//   `in_data` to the sum or subtracts it, depending on `in_sub`. The saturated result
//   is then offered on an output valid/ready handshake.
//
// Ports
//   clk, rst_n        : single clock, synchronous active-low reset
//   start, len        : begin a burst of `len` beats (sampled in IDLE only)
//   in_valid/in_ready : upstream beat handshake
//   in_data, in_sub   : signed product; 1 = subtract, 0 = add
//   out_valid/out_ready : result handshake
//   out_data, out_ovf : saturated sum and sticky saturation flag for the burst
//   busy              : high while a burst is in progress or its result is pending
module fxp_accumulate_stage #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf,
  output logic             busy
);

  typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

  state_e           r_state;
  logic [WIDTH-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;

  logic             w_beat;
  logic [WIDTH:0]   w_a_ext;
  logic [WIDTH:0]   w_b_ext;
  logic [WIDTH:0]   w_b_op;
  logic [WIDTH:0]   w_sum;
  logic             w_sat_hit;
  logic [WIDTH-1:0] w_sat;

  // Outputs decode from state and registers only, so no input reaches an output.
  assign in_ready  = (r_state == StAccum);
  assign out_valid = (r_state == StDone);
  assign busy      = (r_state != StIdle);
  assign out_data  = out_valid ? r_acc : '0;
  assign out_ovf   = out_valid ? r_ovf : 1'b0;

  assign w_beat = in_valid && in_ready;

  // Both operands are widened by one bit before the add. Subtract inverts b and
  // injects a carry, so subtracting the most negative value still gives the
  // true positive magnitude.
  always_comb begin
    w_a_ext   = {r_acc[WIDTH-1], r_acc};
    w_b_ext   = {in_data[WIDTH-1], in_data};
    w_b_op    = in_sub ? ~w_b_ext : w_b_ext;
    w_sum     = w_a_ext + w_b_op + {{WIDTH{1'b0}}, in_sub};
    w_sat_hit = w_sum[WIDTH] ^ w_sum[WIDTH-1];
    w_sat     = w_sum[WIDTH-1:0];
    if (w_sat_hit) begin
      // The true sign is bit WIDTH, which selects the clamp direction.
      w_sat = w_sum[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (start) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
            if (len != '0) begin
              r_cnt   <= len;
              r_state <= StAccum;
            end else begin
              r_cnt   <= '0;
              r_state <= StDone;
            end
          end
        end
        StAccum: begin
          if (w_beat) begin
            r_acc <= w_sat;
            r_ovf <= r_ovf | w_sat_hit;
            r_cnt <= r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) r_state <= StDone;
          end
        end
        StDone: begin
          if (out_ready) r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_fxp_accumulate_stage.sv
module tb_fxp_accumulate_stage;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [CNT_W-1:0] len;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_ovf;
  logic             busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [WIDTH-1:0] q_data[$];
  bit               q_sub[$];
  bit               q_vpat[$];

  fxp_accumulate_stage #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .len      (len),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_sub   (in_sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_ovf  (out_ovf),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: plain integer sum, clamped to the signed 16-bit range after each beat.
  task automatic model(output logic [WIDTH-1:0] res, output bit ovf);
    int a;
    int v;
    a   = 0;
    ovf = 1'b0;
    foreach (q_data[i]) begin
      v = $signed(q_data[i]);
      a = q_sub[i] ? a - v : a + v;
      if (a > 32767) begin
        a   = 32767;
        ovf = 1'b1;
      end else if (a < -32768) begin
        a   = -32768;
        ovf = 1'b1;
      end
    end
    res = a[WIDTH-1:0];
  endtask

  task automatic push(input logic [WIDTH-1:0] d, input bit s);
    q_data.push_back(d);
    q_sub.push_back(s);
  endtask

  // Runs one burst from q_data/q_sub. vmode: 0 always valid, 1 random gaps,
  // 2 follow q_vpat then always valid. inj_start pulses start on an idle beat.
  task automatic burst(input string tag, input int vmode, input int hold, input bit inj_start);
    logic [WIDTH-1:0] exp_d;
    bit               exp_o;
    int               n;
    int               idx;
    int               budget;
    bit               injected;
    model(exp_d, exp_o);
    n        = q_data.size();
    injected = 1'b0;
    @(negedge clk);
    start = 1'b1;
    len   = CNT_W'(n);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    len   = CNT_W'($urandom_range(0, 255));
    idx    = 0;
    budget = 0;
    while (idx < n && budget < 1000) begin
      check({tag, "/in_ready"}, 32'(in_ready), 32'd1);
      in_data = WIDTH'($urandom);
      in_sub  = 1'($urandom);
      if (vmode == 0) in_valid = 1'b1;
      else if (vmode == 2 && q_vpat.size() > 0) in_valid = q_vpat.pop_front();
      else if (vmode == 2) in_valid = 1'b1;
      else in_valid = ($urandom_range(0, 2) != 0);
      if (inj_start && !injected && !in_valid) begin
        start    = 1'b1;
        len      = 8'd0;
        injected = 1'b1;
      end
      if (in_valid) begin
        in_data = q_data[idx];
        in_sub  = q_sub[idx];
      end
      @(posedge clk);
      if (in_valid) idx++;
      budget++;
      @(negedge clk);
      start    = 1'b0;
      in_valid = 1'b0;
    end
    if (budget >= 1000) check({tag, "/timeout"}, 32'(idx), 32'(n));
    // First negedge after the last accepted beat: result must already be up.
    check({tag, "/out_valid"}, 32'(out_valid), 32'd1);
    check({tag, "/out_data"}, 32'(out_data), 32'(exp_d));
    check({tag, "/out_ovf"}, 32'(out_ovf), 32'(exp_o));
    check({tag, "/in_ready_done"}, 32'(in_ready), 32'd0);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'($urandom);
      @(posedge clk);
      @(negedge clk);
      check({tag, "/hold_valid"}, 32'(out_valid), 32'd1);
      check({tag, "/hold_data"}, 32'({out_ovf, out_data}), 32'({exp_o, exp_d}));
      check({tag, "/hold_ready"}, 32'(in_ready), 32'd0);
      check({tag, "/hold_busy"}, 32'(busy), 32'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "/idle_valid"}, 32'(out_valid), 32'd0);
    check({tag, "/idle_busy"}, 32'(busy), 32'd0);
    q_data.delete();
    q_sub.delete();
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    len       = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_sub    = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst/outs", 32'({in_ready, out_valid, out_ovf, busy}), 32'd0);
    check("rst/out_data", 32'(out_data), 32'd0);
    rst_n = 1'b1;

    push(16'h0100, 0); push(16'h0200, 0); push(16'h0080, 1);
    burst("basic", 0, 0, 0);
    push(16'h7000, 0); push(16'h7000, 0);
    burst("possat", 0, 0, 0);
    push(16'h0001, 0);
    burst("ovfclr", 0, 0, 0);
    push(16'h8000, 1);
    burst("sub8000", 0, 0, 0);
    push(16'h8000, 0); push(16'hFFFF, 0);
    burst("negsat", 0, 0, 0);
    q_vpat = '{1, 0, 0, 1, 1, 0, 1};
    push(16'h0001, 0); push(16'h0001, 0); push(16'h0001, 0); push(16'h0001, 0);
    burst("gaps", 2, 5, 0);
    burst("len0", 0, 1, 0);
    push(16'h0005, 0); push(16'h0003, 1); push(16'h0100, 0);
    burst("ignstart", 1, 0, 1);

    // Reset mid-burst after two of five beats.
    @(negedge clk);
    start = 1'b1;
    len   = 8'd5;
    @(posedge clk);
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = 16'h0123;
    repeat (2) @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst/outs", 32'({in_ready, out_valid, busy}), 32'd0);
    check("midrst/out_data", 32'(out_data), 32'd0);
    push(16'h0010, 0);
    burst("postrst", 0, 0, 0);

    for (int b = 0; b < 25; b++) begin
      int n;
      n = $urandom_range(0, 12);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 1) != 0) push(16'($urandom), 1'($urandom));
        else push(16'($urandom_range(0, 1023)) - 16'd512, 1'($urandom));
      end
      burst($sformatf("rand%0d", b), 1, $urandom_range(0, 3), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
